exmem_memwb_pipe: RTL and testbench

- Holds the EX/MEM and MEM/WB pipeline registers of the 16-register CPU pipeline.
- Performs the data-memory access for loads and stores, using a single-outstanding request/acknowledge handshake.
- Produces the EM_RD/EM_RegWrite and MWB_RD/MWB_RegWrite values that the forwarding unit compares against ID operands, plus the matching forwarded data.
- Sits between the EX stage and the register-file write port.

---
 rtl/exmem_memwb_pipe.sv | 95 +++++++++
 tb/tb_exmem_memwb_pipe.sv | 123 ++++++++++++
 2 files changed

// File: rtl/exmem_memwb_pipe.sv
// exmem_memwb_pipe: EX/MEM and MEM/WB pipeline registers with a single-outstanding data-memory handshake
module exmem_memwb_pipe #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              ex_flush,
  output logic              ex_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [REG_W-1:0]  em_rd,
  output logic              em_regwrite,
  output logic [DATA_W-1:0] em_data,
  output logic              em_load_pending,
  output logic [REG_W-1:0]  mwb_rd,
  output logic              mwb_regwrite,
  output logic [DATA_W-1:0] mwb_data
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state_q, state_d;
  logic em_valid_q, em_valid_d, em_regwrite_q, em_regwrite_d;
  logic em_memread_q, em_memread_d, em_memwrite_q, em_memwrite_d;
  logic [REG_W-1:0] em_rd_q, em_rd_d, mwb_rd_q, mwb_rd_d;
  logic [DATA_W-1:0] em_alu_q, em_alu_d, em_sd_q, em_sd_d, mwb_data_q, mwb_data_d;
  logic mwb_regwrite_q, mwb_regwrite_d;
  logic em_mem, adv, ex_live;
  always_comb begin
    em_mem         = em_valid_q & (em_memread_q | em_memwrite_q);
    adv            = ~em_mem | mem_ack;
    ex_live        = ex_valid & ~ex_flush;
    state_d        = (em_mem & ~mem_ack) ? S_WAIT : S_IDLE;
    em_valid_d     = adv ? ex_live : em_valid_q;
    em_regwrite_d  = adv ? ex_live & ex_regwrite : em_regwrite_q;
    em_memread_d   = adv ? ex_live & ex_memread : em_memread_q;
    em_memwrite_d  = adv ? ex_live & ex_memwrite : em_memwrite_q;
    em_rd_d        = adv ? ex_rd : em_rd_q;
    em_alu_d       = adv ? ex_alu_result : em_alu_q;
    em_sd_d        = adv ? ex_store_data : em_sd_q;
    // a stalled EM pushes bubbles into MWB so a write-back never repeats
    mwb_regwrite_d = adv & em_valid_q & em_regwrite_q & ~em_memwrite_q;
    mwb_rd_d       = adv ? em_rd_q : mwb_rd_q;
    mwb_data_d     = adv ? (em_memread_q ? mem_rdata : em_alu_q) : mwb_data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      em_valid_q     <= 1'b0;
      em_regwrite_q  <= 1'b0;
      em_memread_q   <= 1'b0;
      em_memwrite_q  <= 1'b0;
      em_rd_q        <= '0;
      em_alu_q       <= '0;
      em_sd_q        <= '0;
      mwb_regwrite_q <= 1'b0;
      mwb_rd_q       <= '0;
      mwb_data_q     <= '0;
    end else begin
      state_q        <= state_d;
      em_valid_q     <= em_valid_d;
      em_regwrite_q  <= em_regwrite_d;
      em_memread_q   <= em_memread_d;
      em_memwrite_q  <= em_memwrite_d;
      em_rd_q        <= em_rd_d;
      em_alu_q       <= em_alu_d;
      em_sd_q        <= em_sd_d;
      mwb_regwrite_q <= mwb_regwrite_d;
      mwb_rd_q       <= mwb_rd_d;
      mwb_data_q     <= mwb_data_d;
    end
  end
  assign ex_ready        = adv;
  assign mem_req         = em_mem & (state_q == S_IDLE);
  assign mem_we          = mem_req & em_memwrite_q;
  assign mem_addr        = mem_req ? em_alu_q : '0;
  assign mem_wdata       = mem_req ? em_sd_q : '0;
  assign em_rd           = em_rd_q;
  assign em_regwrite     = em_valid_q & em_regwrite_q;
  assign em_data         = em_alu_q;
  assign em_load_pending = em_valid_q & em_memread_q & ~mem_ack;
  assign mwb_rd          = mwb_rd_q;
  assign mwb_regwrite    = mwb_regwrite_q;
  assign mwb_data        = mwb_data_q;
endmodule

// File: tb/tb_exmem_memwb_pipe.sv
// tb_exmem_memwb_pipe: random and directed traffic against a slot-level pipeline model with a latency-randomized memory
module tb_exmem_memwb_pipe;
  logic clk = 0, rst_n = 0;
  logic ex_valid = 0, ex_regwrite = 0, ex_memread = 0, ex_memwrite = 0, ex_flush = 0;
  logic [3:0] ex_rd = 0;
  logic [15:0] ex_alu_result = 0, ex_store_data = 0, mem_rdata = 0;
  logic mem_ack = 0;
  logic ex_ready, mem_req, mem_we, em_regwrite, em_load_pending, mwb_regwrite;
  logic [15:0] mem_addr, mem_wdata, em_data, mwb_data;
  logic [3:0] em_rd, mwb_rd;
  int checks = 0, errors = 0;
  typedef struct packed { logic v, rw, mr, mw; logic [3:0] rd; logic [15:0] a, s; } em_t;
  typedef struct packed { logic v; logic [3:0] rd; logic [15:0] d; } wb_t;
  em_t em;
  wb_t wb;
  logic iss, pend, late;
  int cnt;
  exmem_memwb_pipe dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_flush(ex_flush), .ex_ready(ex_ready), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .em_rd(em_rd), .em_regwrite(em_regwrite), .em_data(em_data),
    .em_load_pending(em_load_pending), .mwb_rd(mwb_rd), .mwb_regwrite(mwb_regwrite), .mwb_data(mwb_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic chk_reset();
    chk("rst_em_rw", em_regwrite, 0);
    chk("rst_wb_rw", mwb_regwrite, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_pend", em_load_pending, 0);
    chk("rst_ready", ex_ready, 1);
    chk("rst_data", {em_data, mwb_data}, 0);
    chk("rst_addr", {mem_addr, mem_wdata}, 0);
    chk("rst_rd", {em_rd, mwb_rd}, 0);
  endtask
  task automatic model_reset();
    em = '0; wb = '0; iss = 0; pend = 0; late = 0; cnt = 0;
  endtask
  task automatic step(input logic v, input logic [3:0] rd, input logic rw, input logic mr, input logic mw,
                      input logic [15:0] alu, input logic [15:0] sd, input logic fl, input int lat);
    logic mem_op, rdy;
    @(negedge clk);
    mem_ack = 0;
    if (late) begin mem_ack = 1; mem_rdata = 16'($urandom); late = 0; end
    else if (pend && cnt == 0) begin mem_ack = 1; mem_rdata = 16'($urandom); pend = 0; end
    else if (pend) cnt--;
    ex_valid = v; ex_rd = rd; ex_regwrite = rw; ex_memread = mr; ex_memwrite = mw;
    ex_alu_result = alu; ex_store_data = sd; ex_flush = fl;
    #1;
    if (mem_req && !pend && !mem_ack) begin
      if (lat == 0) begin mem_ack = 1; mem_rdata = 16'($urandom); end
      else begin pend = 1; cnt = lat - 1; end
    end
    #1;
    mem_op = em.v && (em.mr || em.mw);
    rdy = !mem_op || mem_ack;
    chk("ex_ready", ex_ready, rdy);
    chk("mem_req", mem_req, mem_op && !iss);
    if (mem_op && !iss) begin
      chk("mem_we", mem_we, em.mw);
      chk("mem_addr", mem_addr, em.a);
      if (em.mw) chk("mem_wdata", mem_wdata, em.s);
    end
    chk("em_rw", em_regwrite, em.v && em.rw);
    if (em.v && em.rw) begin chk("em_rd", em_rd, em.rd); chk("em_data", em_data, em.a); end
    chk("em_pend", em_load_pending, em.v && em.mr && !mem_ack);
    chk("wb_rw", mwb_regwrite, wb.v);
    if (wb.v) begin chk("wb_rd", mwb_rd, wb.rd); chk("wb_data", mwb_data, wb.d); end
    if (rdy) begin
      wb.v = em.v && em.rw && !em.mw; wb.rd = em.rd; wb.d = em.mr ? mem_rdata : em.a;
      em.v = v && !fl; em.rw = rw; em.mr = mr && em.v; em.mw = mw && em.v;
      em.rd = rd; em.a = alu; em.s = sd; iss = 0;
    end else begin
      wb.v = 0; iss = 1;
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask
  initial begin
    model_reset();
    #2 chk_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    step(1, 12, 1, 0, 0, 16'h00AA, 0, 0, 1);
    step(1, 13, 1, 0, 0, 16'h00BB, 0, 0, 1);
    idle(2);
    step(1, 13, 1, 1, 0, 16'h0040, 0, 0, 2);
    idle(5);
    step(1, 2, 0, 0, 1, 16'h0010, 16'h5555, 0, 0);
    step(1, 0, 1, 0, 0, 16'h0077, 0, 0, 1);
    step(1, 15, 1, 1, 0, 16'h0020, 0, 1, 0);
    idle(3);
    for (int i = 0; i < 600; i++) begin
      int k;
      k = $urandom_range(0, 9);
      step(k != 0, 4'($urandom), 1'($urandom), k inside {1, 2, 3}, k inside {4, 5},
           16'($urandom), 16'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 3));
    end
    idle(6);
    step(1, 9, 1, 1, 0, 16'h0080, 0, 0, 9);
    idle(1);
    @(negedge clk);
    rst_n = 0;
    #2 chk_reset();
    model_reset();
    @(negedge clk);
    rst_n = 1;
    late = 1;
    idle(3);
    chk("late_ack_wb", mwb_regwrite, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
